// File: rtl/rom_load_seq.sv
// ROM download sequencer: buffers HPS download writes, drains them on core write slots, owns core reset.
// Optional running byte checksum enabled by ROM_LOAD_CHECKSUM_EN.
module rom_load_seq #(
  parameter int unsigned AW         = 16,
  parameter int unsigned ROM_SIZE   = 65536,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned HOLD       = 16,
  parameter logic [7:0]  CHK_EXPECT = 8'h00
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [24:0]   dl_addr,
  input  logic [7:0]    dl_dout,
  input  logic          wr_slot,
  output logic [AW-1:0] rom_ad,
  output logic [7:0]    rom_dt,
  output logic          rom_en,
  output logic          core_rst,
  output logic          busy,
  output logic          ovf,
  output logic [7:0]    chk_sum,
  output logic          chk_ok
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned EW = AW + 8;

  typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_DRAIN, ST_HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          empty, full, push_req, push, pop;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign push_req = dl_wr & dl_active & ({7'd0, dl_addr} < 32'(ROM_SIZE));
  assign pop      = ~empty & wr_slot;
  // A push into a full FIFO survives only when the same edge frees a slot
  assign push     = push_req & (~full | pop);

  // Next-state logic; a new download always wins over draining or holding
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RUN:   if (dl_active) state_nxt = ST_LOAD;
      ST_LOAD:  if (!dl_active) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (dl_active) begin
          state_nxt = ST_LOAD;
        end else if (empty && !rom_en) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CW'(HOLD - 1);
        end
      end
      ST_HOLD: begin
        if (dl_active)        state_nxt = ST_LOAD;
        else if (cnt == '0)   state_nxt = ST_RUN;
        else                  cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state    <= ST_HOLD;
      cnt      <= CW'(HOLD - 1);
      core_rst <= 1'b1;
      busy     <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      core_rst <= (state_nxt != ST_RUN);
      busy     <= (state_nxt != ST_RUN);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst_n && push) mem[wr_ptr] <= {dl_addr[AW-1:0], dl_dout};
  end

  // FIFO pointers and ROM write port
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rom_en <= 1'b0;
      rom_ad <= '0;
      rom_dt <= '0;
      ovf    <= 1'b0;
    end else begin
      rom_en <= pop;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr           <= rd_ptr + PW'(1);
        {rom_ad, rom_dt} <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (push_req && !push) ovf <= 1'b1;
    end
  end

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [7:0] sum_nxt;

  // Sum restarts on every fresh entry into LOAD
  always_comb begin
    sum_nxt = chk_sum;
    if (state_nxt == ST_LOAD && state != ST_LOAD) sum_nxt = '0;
    else if (pop)                                 sum_nxt = chk_sum + mem[rd_ptr][7:0];
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      chk_sum <= '0;
      chk_ok  <= 1'b0;
    end else begin
      chk_sum <= sum_nxt;
      chk_ok  <= (state_nxt == ST_RUN) && (sum_nxt == CHK_EXPECT);
    end
  end
`else
  logic [7:0] unused_chk;

  assign unused_chk = CHK_EXPECT;
  assign chk_sum    = '0;
  assign chk_ok     = 1'b1;
`endif

endmodule

// File: doc/rom_load_seq.md
# rom_load_seq

Sequences the HPS ROM download stream into the game core's ROM write port (address, data, enable) and owns the core's reset during and after a download. Incoming download writes are buffered in a small FIFO and drained only on core-granted write slots, so the core's ROM clock domain is never overrun. After the stream ends and the FIFO is empty, the core is held in reset for a fixed interval and then released. Sits between `hps_io` and the game core in the top-level `emu`.

## Interface
Parameters:
- `AW`, 16 — core ROM address width.
- `ROM_SIZE`, 65536 — writes with `dl_addr >= ROM_SIZE` are discarded.
- `DEPTH`, 4 — FIFO entries; power of two, ≥2.
- `HOLD`, 16 — post-download reset hold, in `clk_sys` cycles; ≥1.
- `CHK_EXPECT`, 8'h00 — expected byte checksum; used only with `ROM_LOAD_CHECKSUM_EN`.

Ports:
- `clk_sys` in 1 — single clock; all logic on the rising edge.
- `rst_n` in 1 — reset, synchronous, active-low.
- `dl_active` in 1 — download in progress (`ioctl_download`).
- `dl_wr` in 1 — one-cycle write strobe (`ioctl_wr`).
- `dl_addr` in 25 — download byte address.
- `dl_dout` in 8 — download byte.
- `wr_slot` in 1 — core grants a ROM write this cycle.
- `rom_ad` out AW — ROM write address, registered.
- `rom_dt` out 8 — ROM write data, registered.
- `rom_en` out 1 — one-cycle ROM write pulse, registered.
- `core_rst` out 1 — core reset, active-high.
- `busy` out 1 — high whenever state ≠ RUN.
- `ovf` out 1 — sticky FIFO overflow flag.
- `chk_sum` out 8 — running byte sum of the current load.
- `chk_ok` out 1 — checksum match.

## Operation
- Reset (`rst_n`=0 at an edge): state=HOLD, hold counter=HOLD-1, FIFO emptied. Output values: `rom_en`=0, `rom_ad`=0, `rom_dt`=0, `core_rst`=1, `busy`=1, `ovf`=0, `chk_sum`=0.
- The FSM has four states:
  - RUN: `core_rst`=0. Goes to LOAD when `dl_active`=1.
  - LOAD: `core_rst`=1. Goes to DRAIN when `dl_active`=0.
  - DRAIN: `core_rst`=1. Goes to HOLD (counter=HOLD-1) when the FIFO is empty and `rom_en`=0. Goes back to LOAD if `dl_active`=1.
  - HOLD: `core_rst`=1. The counter decrements each cycle. Goes to RUN in the cycle after the counter reads 0. Goes to LOAD if `dl_active`=1, which takes priority over the counter.
- Push condition: `dl_wr` & `dl_active` & (`dl_addr` < `ROM_SIZE`). The entry stored is {`dl_addr[AW-1:0]`, `dl_dout`}. Pushes are accepted in any state.
- Pop condition: FIFO non-empty & `wr_slot`.
  - At the pop edge, `rom_ad`/`rom_dt` are loaded with the head entry and `rom_en` is set to 1.
  - `rom_en` is 0 on every edge with no pop.
  - `rom_ad`/`rom_dt` hold their last value between pops.
- Full FIFO:
  - A push arriving at the same edge as a pop is accepted.
  - Any other push while full is dropped and `ovf` is set to 1. `ovf` is cleared only by reset.
- Push into an empty FIFO with `wr_slot` high in the same cycle: the entry is not popped that edge (no bypass).
- Pointers wrap modulo DEPTH. The count saturates neither way.

## Timing
- Push-to-write latency: `dl_wr` sampled at edge N into an empty FIFO, with `wr_slot`=1 during cycle N+1 → pop at edge N+1 → `rom_en`=1 during cycle N+1..N+2 (one clock).
- Sustained throughput is one byte per cycle while `wr_slot`=1.
- Release latency: the last pop at edge P → `rom_en` falls at P+1 → DRAIN→HOLD at P+2 → `core_rst`=0 after HOLD further cycles.
- `dl_active` rising in RUN raises `core_rst` at the next edge.
- Reset mid-load discards the FIFO contents. No partial `rom_en` pulse is emitted after the reset edge.

## Configuration
- Macro `ROM_LOAD_CHECKSUM_EN`, defined:
  - `chk_sum` is cleared on any transition into LOAD from another state.
  - On every pop, `chk_sum` becomes `chk_sum` + popped data, modulo 256.
  - `chk_ok` = (state==RUN) & (`chk_sum`==`CHK_EXPECT`).
- Macro undefined: `chk_sum` is tied to 0, `chk_ok` is tied to 1, and no adder is built.

## Test plan
- Reset release, no download: hold `rst_n`=0 then 1, with HOLD=16 → `core_rst`=1 for 16 cycles after release then 0. `busy` tracks `core_rst`. `rom_en` stays 0.
- Single byte: `dl_active`=1, one `dl_wr` with addr 0x0123 and data 0xA5, `wr_slot`=1 → exactly one `rom_en` pulse two edges later with `rom_ad`=0x0123 and `rom_dt`=0xA5.
- Throttled stream: 8 back-to-back writes, `wr_slot` high every 4th cycle, DEPTH=4 → `ovf`=1, and exactly 4+(pops during the burst) `rom_en` pulses, in address order.
- Address filter: a write to 0x10000 with ROM_SIZE=65536 → no FIFO entry and no `rom_en`.
- Re-entry: `dl_active` reasserted during HOLD at counter=5 → state returns to LOAD and `core_rst` stays 1. After `dl_active` falls, the full HOLD interval restarts.
- Checksum (macro on): bytes 0x10, 0x20, 0xF0 → `chk_sum`=0x20. With CHK_EXPECT=0x20, `chk_ok`=1 once RUN is reached. Reset mid-load → `chk_sum`=0 and `rom_en`=0 at the next edge.
